// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults.
// Holds address/instruction widths, reset PC, NOP encoding and the queue entry.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO used for request PCs and fetched instructions.
// Ports: clk, reset, flush_i, push_i/data_i, pop_i, count_o, head_o, empty_o.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [AW-1:0] STEP_C = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == FULL_C);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full queue is accepted only when a pop frees a slot.
    assign do_push = push_i && (!full || do_pop);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + STEP_C;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + STEP_C;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues imem requests, queues returned words for IF/ID.
// Ports: clk/reset, imem_req_*, imem_rsp_*, redirect_*, stall, instr_valid/instr_out/pc_out.
// Optional FETCH_PERF_CNT_EN adds perf_fetched and perf_dropped counters.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned QDEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned EW = INSTR_W + ADDR_W;
    localparam logic [CW:0]     QD_C = (CW + 1)'(QDEPTH);
    localparam logic [CW-1:0]   ONE_C = CW'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]     outstanding;
    logic [ADDR_W-1:0] rq_head;
    logic              rq_empty;

    logic [CW-1:0]     iq_count;
    logic [EW-1:0]     iq_head;
    logic              iq_empty;

    logic [CW:0]       inflight;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              pop;
    logic              unused_rpc_lo;

    assign unused_rpc_lo = ^redirect_pc[1:0];

    // Credits cover both in-flight requests and queued words; a pop in the
    // same cycle is not credited back until the next cycle.
    assign inflight = {1'b0, outstanding} + {1'b0, iq_count};
    assign imem_req_valid = !reset && !redirect_valid && (inflight < QD_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire = imem_req_valid && imem_req_ready;

    // Any response arriving during a redirect belongs to the old stream.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    assign instr_valid = !iq_empty;
    assign pop = instr_valid && !stall && !redirect_valid;
    assign instr_out = instr_valid ? iq_head[EW-1:ADDR_W] : NOP_INSTR;
    assign pc_out    = instr_valid ? iq_head[ADDR_W-1:0] : '0;

    // Tracks the PC of every accepted request; its occupancy is the
    // outstanding-request count. Never flushed: old responses still pop it.
    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ADDR_W)
    ) u_req_pc_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .data_i  (fetch_pc_q),
        .pop_i   (imem_rsp_valid),
        .count_o (outstanding),
        .head_o  (rq_head),
        .empty_o (rq_empty)
    );

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_instr_q (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep),
        .data_i  ({imem_rsp_data, rq_head}),
        .pop_i   (pop),
        .count_o (iq_count),
        .head_o  (iq_head),
        .empty_o (iq_empty)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            drop_cnt_d = imem_rsp_valid ? (outstanding - ONE_C) : outstanding;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [31:0] flushed_n;

    // Queue entries thrown away by a redirect count as dropped work.
    assign flushed_n = redirect_valid ? 32'(iq_count) : 32'd0;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_dropped_d = perf_dropped_q + 32'(rsp_drop) + flushed_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`else
    // Counters compiled out; fetch behaviour is unchanged.
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && rq_empty))
                else $error("imem response with no request outstanding");
        end
    end
`endif

endmodule
